// File: rtl/mure_pkg.sv
// Shared trace-encoder types: field widths, the closed-block record and trap itype codes.
package mure_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned ITYPE_LEN   = 4;
    localparam int unsigned IRETIRE_LEN = 6;
    localparam int unsigned CAUSE_LEN   = 5;
    localparam int unsigned PRIV_LEN    = 2;

    localparam logic [ITYPE_LEN-1:0] ITYPE_EXC = ITYPE_LEN'(1);
    localparam logic [ITYPE_LEN-1:0] ITYPE_INT = ITYPE_LEN'(2);

    typedef struct packed {
        logic [IRETIRE_LEN-1:0] iretire;
        logic                   ilastsize;
        logic [ITYPE_LEN-1:0]   itype;
        logic [XLEN-1:0]        iaddr;
        logic [PRIV_LEN-1:0]    priv;
        logic [CAUSE_LEN-1:0]   cause;
        logic [XLEN-1:0]        tval;
    } block_entry_s;

    function automatic logic is_trap(input logic [ITYPE_LEN-1:0] itype);
        return (itype == ITYPE_EXC) || (itype == ITYPE_INT);
    endfunction

    function automatic block_entry_s new_block(
        input logic [IRETIRE_LEN-1:0] iretire,
        input logic                   ilastsize,
        input logic [ITYPE_LEN-1:0]   itype,
        input logic [XLEN-1:0]        iaddr,
        input logic [PRIV_LEN-1:0]    priv,
        input logic [CAUSE_LEN-1:0]   cause,
        input logic [XLEN-1:0]        tval
    );
        block_entry_s b;
        b.iretire   = iretire;
        b.ilastsize = ilastsize;
        b.itype     = itype;
        b.iaddr     = iaddr;
        b.priv      = priv;
        b.cause     = cause;
        b.tval      = tval;
        return b;
    endfunction

endpackage

// File: rtl/mure_block_fifo.sv
// Circular buffer of closed trace blocks: several pushes and several pops per cycle,
// with the first NPOP entries from the head always visible.
module mure_block_fifo
    import mure_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned NPUSH = 4,
    parameter int unsigned NPOP  = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [$clog2(NPUSH+1)-1:0]     push_cnt_i,
    input  block_entry_s [NPUSH-1:0]       push_data_i,
    input  logic [$clog2(NPOP+1)-1:0]      pop_cnt_i,
    output block_entry_s [NPOP-1:0]        head_o,
    output logic [$clog2(DEPTH):0]         usage_o
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned PCNT_W = $clog2(NPUSH+1);

    block_entry_s       mem_q [DEPTH];
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W:0]     usage_q, usage_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wptr_d  = wptr_q + PTR_W'(push_cnt_i);
        rptr_d  = rptr_q + PTR_W'(pop_cnt_i);
        usage_d = usage_q + (PTR_W+1)'(push_cnt_i) - (PTR_W+1)'(pop_cnt_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            usage_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            usage_q <= usage_d;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < NPUSH; i++) begin
            if (PCNT_W'(i) < push_cnt_i) begin
                mem_q[wptr_q + PTR_W'(i)] <= push_data_i[i];
            end
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < NPOP; k++) begin
            head_o[k] = mem_q[rptr_q + PTR_W'(k)];
        end
        usage_o = usage_q;
    end

endmodule

// File: rtl/mure_block_packer.sv
// Folds NRET itype-tagged retirements per cycle into E-trace instruction blocks and
// presents up to N buffered blocks per cycle to the trace encoder.
module mure_block_packer
    import mure_pkg::*;
#(
    parameter int unsigned NRET  = 2,
    parameter int unsigned N     = 2,
    parameter int unsigned DEPTH = 16
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NRET-1:0]                    valid_i,
    input  logic [NRET-1:0][XLEN-1:0]          pc_i,
    input  logic [NRET-1:0][ITYPE_LEN-1:0]     itype_i,
    input  logic [NRET-1:0]                    compressed_i,
    input  logic [PRIV_LEN-1:0]                priv_i,
    input  logic                               exc_valid_i,
    input  logic                               exc_irq_i,
    input  logic [CAUSE_LEN-1:0]               cause_i,
    input  logic [XLEN-1:0]                    tval_i,
    input  logic [XLEN-1:0]                    epc_i,
    input  logic                               ready_i,
    input  logic                               clear_overflow_i,
    output logic [N-1:0]                       valid_o,
    output logic [N-1:0][IRETIRE_LEN-1:0]      iretire_o,
    output logic [N-1:0]                       ilastsize_o,
    output logic [N-1:0][ITYPE_LEN-1:0]        itype_o,
    output logic [N-1:0][XLEN-1:0]             iaddr_o,
    output logic [N-1:0][PRIV_LEN-1:0]         priv_o,
    output logic [CAUSE_LEN-1:0]               cause_o,
    output logic [XLEN-1:0]                    tval_o,
    output logic                               stall_o,
    output logic                               overflow_o,
    output logic [$clog2(DEPTH):0]             usage_o
);

    localparam int unsigned NCL   = NRET + 2;
    localparam int unsigned CNT_W = $clog2(NCL+1);
    localparam int unsigned POP_W = $clog2(N+1);
    localparam int unsigned USE_W = $clog2(DEPTH) + 1;
    // Closing here leaves room for 2*NRET more halfwords without wrapping iretire.
    localparam logic [IRETIRE_LEN-1:0] IRET_THRESH = IRETIRE_LEN'((2**IRETIRE_LEN) - 1 - 2*NRET);
    localparam logic [USE_W-1:0]       STALL_AT    = USE_W'(DEPTH - NRET - 2);

    logic                    open_q, open_d;
    logic [XLEN-1:0]         addr_q, addr_d;
    logic [IRETIRE_LEN-1:0]  iret_q, iret_d;
    logic                    last_q, last_d;
    logic [PRIV_LEN-1:0]     bpriv_q, bpriv_d;
    logic                    overflow_q, overflow_d;

    logic [NCL-1:0]          slot_v_s;
    block_entry_s [NCL-1:0]  slot_s;
    block_entry_s [NCL-1:0]  push_s;
    logic [CNT_W-1:0]        push_cnt_s;
    block_entry_s [N-1:0]    head_s;
    logic [USE_W-1:0]        usage_s;
    logic [N-1:0]            lane_v_s;
    logic [POP_W-1:0]        pop_cnt_s;
    logic                    stall_s;
    logic                    drop_s;
    logic                    grp_s;
    logic [ITYPE_LEN-1:0]    exc_type_s;

    assign stall_s = (usage_s > STALL_AT);
    assign drop_s  = stall_s && ((|valid_i) || exc_valid_i);

    // Fold: slot 0 is the pre-close, slot 1+i belongs to port i, the last slot to the trap.
    always_comb begin
        open_d     = open_q;
        addr_d     = addr_q;
        iret_d     = iret_q;
        last_d     = last_q;
        bpriv_d    = bpriv_q;
        slot_v_s   = '0;
        slot_s     = '0;
        exc_type_s = exc_irq_i ? ITYPE_INT : ITYPE_EXC;
        if (!stall_s) begin
            if (open_d && ((priv_i != bpriv_d) || (iret_d >= IRET_THRESH))) begin
                slot_v_s[0] = 1'b1;
                slot_s[0]   = new_block(iret_d, last_d, ITYPE_LEN'(0), addr_d, bpriv_d,
                                        CAUSE_LEN'(0), XLEN'(0));
                open_d      = 1'b0;
            end else begin
                slot_v_s[0] = 1'b0;
            end
            for (int unsigned i = 0; i < NRET; i++) begin
                if (valid_i[i]) begin
                    if (!open_d) begin
                        open_d  = 1'b1;
                        addr_d  = pc_i[i];
                        iret_d  = IRETIRE_LEN'(0);
                        bpriv_d = priv_i;
                    end else begin
                        open_d  = 1'b1;
                    end
                    iret_d = iret_d + (compressed_i[i] ? IRETIRE_LEN'(1) : IRETIRE_LEN'(2));
                    last_d = ~compressed_i[i];
                    if (itype_i[i] != ITYPE_LEN'(0)) begin
                        slot_v_s[i+1] = 1'b1;
                        slot_s[i+1]   = new_block(iret_d, last_d, itype_i[i], addr_d, bpriv_d,
                                                  CAUSE_LEN'(0), XLEN'(0));
                        open_d        = 1'b0;
                    end else begin
                        slot_v_s[i+1] = 1'b0;
                    end
                end else begin
                    slot_v_s[i+1] = 1'b0;
                end
            end
            if (exc_valid_i) begin
                slot_v_s[NCL-1] = 1'b1;
                if (open_d) begin
                    slot_s[NCL-1] = new_block(iret_d, last_d, exc_type_s, addr_d, bpriv_d,
                                              cause_i, tval_i);
                end else begin
                    slot_s[NCL-1] = new_block(IRETIRE_LEN'(0), 1'b0, exc_type_s, epc_i, priv_i,
                                              cause_i, tval_i);
                end
                open_d = 1'b0;
            end else begin
                slot_v_s[NCL-1] = 1'b0;
            end
        end else begin
            open_d = open_q;
        end
    end

    // Pack the occupied slots densely, preserving order, for the FIFO push port.
    always_comb begin
        push_cnt_s = '0;
        push_s     = '0;
        for (int unsigned j = 0; j < NCL; j++) begin
            if (slot_v_s[j]) begin
                for (int unsigned k = 0; k < NCL; k++) begin
                    push_s[k] = (CNT_W'(k) == push_cnt_s) ? slot_s[j] : push_s[k];
                end
                push_cnt_s = push_cnt_s + CNT_W'(1);
            end else begin
                push_cnt_s = push_cnt_s;
            end
        end
    end

    always_comb begin
        overflow_d = overflow_q;
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (clear_overflow_i) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            open_q     <= 1'b0;
            addr_q     <= '0;
            iret_q     <= '0;
            last_q     <= 1'b0;
            bpriv_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            open_q     <= open_d;
            addr_q     <= addr_d;
            iret_q     <= iret_d;
            last_q     <= last_d;
            bpriv_q    <= bpriv_d;
            overflow_q <= overflow_d;
        end
    end

    mure_block_fifo #(
        .DEPTH (DEPTH),
        .NPUSH (NCL),
        .NPOP  (N)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_cnt_i  (push_cnt_s),
        .push_data_i (push_s),
        .pop_cnt_i   (pop_cnt_s),
        .head_o      (head_s),
        .usage_o     (usage_s)
    );

    // A trap block travels alone: it ends a group unless it is already at the head.
    always_comb begin
        grp_s     = 1'b1;
        lane_v_s  = '0;
        pop_cnt_s = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (grp_s && (USE_W'(k) < usage_s)) begin
                if (k == 0) begin
                    lane_v_s[k] = 1'b1;
                    grp_s       = !is_trap(head_s[k].itype);
                end else if (!is_trap(head_s[k].itype)) begin
                    lane_v_s[k] = 1'b1;
                end else begin
                    grp_s       = 1'b0;
                end
            end else begin
                grp_s = 1'b0;
            end
            if (ready_i && lane_v_s[k]) begin
                pop_cnt_s = pop_cnt_s + POP_W'(1);
            end else begin
                pop_cnt_s = pop_cnt_s;
            end
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < N; k++) begin
            valid_o[k]     = lane_v_s[k];
            iretire_o[k]   = lane_v_s[k] ? head_s[k].iretire   : IRETIRE_LEN'(0);
            ilastsize_o[k] = lane_v_s[k] ? head_s[k].ilastsize : 1'b0;
            itype_o[k]     = lane_v_s[k] ? head_s[k].itype     : ITYPE_LEN'(0);
            iaddr_o[k]     = lane_v_s[k] ? head_s[k].iaddr     : XLEN'(0);
            priv_o[k]      = lane_v_s[k] ? head_s[k].priv      : PRIV_LEN'(0);
        end
        if (lane_v_s[0] && is_trap(head_s[0].itype)) begin
            cause_o = head_s[0].cause;
            tval_o  = head_s[0].tval;
        end else begin
            cause_o = CAUSE_LEN'(0);
            tval_o  = XLEN'(0);
        end
        stall_o    = stall_s;
        overflow_o = overflow_q;
        usage_o    = usage_s;
    end

endmodule
